// File: rtl/multiword_add_ctrl.sv
// Multi-precision add sequencer: streams WORDS 64-bit limbs LS-first through an external
// adder, chaining carries. Optional last-limb signed overflow flag under MWADD_OVF_EN.
module multiword_add_ctrl #(
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  sel_in,
  input  logic        cin_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_a,
  input  logic [63:0] in_b,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  output logic        add_cin,
  output logic [1:0]  add_select,
  input  logic [63:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_sum,
  output logic        out_last,
  output logic        out_carry,
  output logic        out_ovf,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(WORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
  localparam logic [CW-1:0] WCNT = CW'(WORDS);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, out_cnt;
  logic          s1_valid, carry_r;
  logic          en, in_hs, cap, out_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == RUN);
    en        = !out_valid || out_ready;
    in_ready  = (state == RUN) && (in_cnt < WCNT) && en;
    in_hs     = in_valid && in_ready;
    cap       = s1_valid && en;
    out_hs    = out_valid && out_ready;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (out_hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign add_cin = carry_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a      <= '0;
      add_b      <= '0;
      add_select <= '0;
      carry_r    <= 1'b0;
      in_cnt     <= '0;
      out_cnt    <= '0;
      s1_valid   <= 1'b0;
      out_sum    <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_carry  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        add_select <= sel_in;
        carry_r    <= cin_in;
        in_cnt     <= '0;
        out_cnt    <= '0;
      end
      if (in_hs) begin
        add_a  <= in_a;
        add_b  <= in_b;
        in_cnt <= in_cnt + CW'(1);
      end
      // Capture wins over a plain handshake so a concurrent pop+capture keeps out_valid high.
      if (cap) begin
        out_sum   <= add_sum;
        carry_r   <= add_cout;
        out_valid <= 1'b1;
        out_last  <= (out_cnt == LAST);
        out_carry <= (out_cnt == LAST) && add_cout;
        out_cnt   <= out_cnt + CW'(1);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_carry <= 1'b0;
      end
      if (in_hs || cap) s1_valid <= in_hs;
      if (out_hs && out_last) done <= 1'b1;
    end
  end

`ifdef MWADD_OVF_EN
  logic a63_r, b63_r, ovf_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a63_r <= 1'b0;
      b63_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      if (in_hs && in_cnt == LAST) begin
        a63_r <= in_a[63];
        b63_r <= in_b[63];
      end
      if (cap)         ovf_r <= (out_cnt == LAST) && (a63_r == b63_r) && (add_sum[63] != a63_r);
      else if (out_hs) ovf_r <= 1'b0;
    end
  end

  assign out_ovf = ovf_r;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: doc/multiword_add_ctrl.md
# multiword_add_ctrl

Multi-precision addition sequencer that sits directly upstream and downstream of the selectable 64-bit adder. It streams WORDS 64-bit limbs, least-significant first, through the adder one limb per cycle and chains each limb's carry-out into the next limb's carry-in. It returns the per-limb sums on a valid/ready output stream, with the final carry attached to the last limb. One operation (start to last output) adds two WORDS×64-bit operands.

## Interface
- WORDS, 4: limbs per operation, ≥1; counter width CW = $clog2(WORDS+1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin operation; sampled only in IDLE
- sel_in  in  2  adder select (00 RCA, 01 CLA, 10 CSEA, 11 CSA); latched on start
- cin_in  in  1  carry-in of limb 0; latched on start
- in_valid / in_ready  in / out  1 / 1  operand limb handshake
- in_a, in_b  in  64 each  operand limbs
- add_a, add_b  out  64 each  to adder a, b (stage-1 registers)
- add_cin  out  1  to adder cin (carry register)
- add_select  out  2  to adder adder_select (latched sel_in)
- add_sum  in  64  from adder sum (combinational, same cycle)
- add_cout  in  1  from adder cout
- out_valid / out_ready  out / in  1 / 1  result limb handshake
- out_sum  out  64  result limb
- out_last  out  1  marks limb WORDS-1
- out_carry  out  1  final carry; meaningful only when out_last=1, else 0
- out_ovf  out  1  signed overflow of the full-width sum (see Configuration)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last output handshake

## Operation
- States: IDLE, RUN.
- IDLE → RUN on start=1.
  - Latch sel_in→add_select and cin_in→carry_r.
  - Clear in_cnt and out_cnt.
- RUN → IDLE on an output handshake with out_last=1; done=1 in the following cycle.
- start during RUN is ignored. sel_in and cin_in changes during RUN are ignored.
- Pipeline advance enable: en = !out_valid || out_ready.
- Input acceptance: in_ready = RUN && in_cnt < WORDS && en.
  - On an input handshake: in_a/in_b → add_a/add_b, s1_valid=1, in_cnt++.
- Result capture: when s1_valid && en:
  - add_sum → out_sum, add_cout → carry_r, out_valid=1.
  - out_last = (out_cnt == WORDS-1); out_cnt++.
  - s1_valid is cleared unless a new limb loads in the same cycle.
- add_cin = carry_r at all times. Limb k therefore uses the carry-out of limb k-1, and limb 0 uses the latched cin_in.
- out_carry = carry_r value captured with the last limb.
- Output handshake without a new capture clears out_valid.
- Arithmetic is unsigned modulo 2^(64·WORDS); the carry bit is out_carry.
- WORDS=1 is a single limb with out_last=1.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0: add_a, add_b, add_cin, add_select, out_sum, out_valid, out_last, out_carry, out_ovf, busy, done, in_ready.
  - Counters 0, s1_valid=0.
- Reset during RUN abandons the operation immediately. No done is produced.
- Latency: an input handshake in cycle c gives out_valid in cycle c+2.
- Throughput: one limb per cycle while out_ready=1.
- Backpressure:
  - out_valid && !out_ready holds out_sum, out_last, s1 and carry_r stable.
  - in_ready=0 for as long as the stall lasts.
  - No limb is lost or duplicated, and order is preserved.
- A simultaneous output handshake and new capture in the same cycle keeps out_valid=1 with the new data.
- in_ready falls the cycle after the WORDS-th input handshake.
- busy rises the cycle after start and falls the cycle after the last output handshake.

## Configuration
- MWADD_OVF_EN defined:
  - Latch in_a[63]/in_b[63] of the last limb.
  - With the last result, out_ovf = (a63==b63) && (out_sum[63]!=a63), treating the full-width operands as two's complement.
  - out_ovf is 0 on non-last limbs.
- MWADD_OVF_EN undefined: out_ovf is tied to 0 and no overflow logic is present.

## Test plan
- WORDS=4, sel=00, cin=0, A limbs all 0xFFFF_FFFF_FFFF_FFFF, B = {0,0,0,1}:
  - out_sum = 0 ×4, carry ripples through every limb.
  - Last limb has out_last=1, out_carry=1; then done pulses.
- cin=1, A=B=0:
  - out_sum limb0 = 1, limbs 1–3 = 0, out_carry=0.
- Repeat the first vector for sel=01, 10, 11:
  - add_select equals the latched value throughout.
  - Identical outputs each time; changing sel_in mid-run has no effect.
- Hold out_ready=0 for 3 cycles after the second result:
  - in_ready=0 and out_sum held during the stall.
  - All 4 limbs delivered in order afterwards; c→c+2 latency confirmed with out_ready=1.
- Pulse start during RUN:
  - Ignored.
- Assert rst_n=0 after 2 input limbs:
  - All outputs 0 and state IDLE immediately, no done.
  - A new start completes normally.
- MWADD_OVF_EN, WORDS=1, A=0x7FFF_FFFF_FFFF_FFFF, B=1:
  - out_sum = 0x8000_0000_0000_0000, out_ovf=1, out_carry=0.
  - Same vector without the macro gives out_ovf=0.
